// File: rtl/lsu_bus_master_if.sv
// Core request/response and memory-map bus signals of the load/store unit.
// The master modport is the LSU side; slave is the core plus memory side.
interface lsu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] bus_addr;
    logic [2:0]  bus_write_enable;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;

    modport master (
        input  req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        input  resp_ready,
        output bus_addr, bus_write_enable, bus_data_in,
        input  bus_data_out
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        output resp_ready,
        input  bus_addr, bus_write_enable, bus_data_in,
        output bus_data_out
    );
endinterface

// File: rtl/lsu_bus_master.sv
// RV32I load/store unit: one request at a time, address generation, alignment
// checks, single-cycle stores and fixed-latency loads with sign/zero extension.
module lsu_bus_master #(
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    lsu_bus_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] addr_c;
    logic        illegal_c, misalign_c, fault_c;
    logic        accept, last_beat;
    logic [31:0] load_ext;

    assign addr_c = bus.req_base + bus.req_offset;
    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        if (bus.req_store)
            illegal_c = !(bus.req_funct3 inside {3'd0, 3'd1, 3'd2});
        else
            illegal_c = bus.req_funct3 inside {3'd3, 3'd6, 3'd7};
        // funct3[1:0] encodes the access size for every legal code
        unique case (bus.req_funct3[1:0])
            2'd1:    misalign_c = addr_c[0];
            2'd2:    misalign_c = (addr_c[1:0] != 2'd0);
            default: misalign_c = 1'b0;
        endcase
        fault_c = illegal_c || misalign_c;
    end

    // Stores finish after one ACCESS cycle; loads wait out the read latency
    assign last_beat = (state == ACCESS) &&
                       (req_q.store || (cnt_q == 4'(READ_LATENCY - 1)));

    always_comb begin
        unique case (req_q.funct3)
            3'd0:    load_ext = {{24{bus.bus_data_out[7]}}, bus.bus_data_out[7:0]};
            3'd4:    load_ext = {24'd0, bus.bus_data_out[7:0]};
            3'd1:    load_ext = {{16{bus.bus_data_out[15]}}, bus.bus_data_out[15:0]};
            3'd5:    load_ext = {16'd0, bus.bus_data_out[15:0]};
            default: load_ext = bus.bus_data_out;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req_valid) state_nxt = fault_c ? RESP : ACCESS;
            ACCESS:  if (last_beat) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q   <= '{store: bus.req_store, funct3: bus.req_funct3,
                             addr: addr_c, wdata: bus.req_wdata};
                cnt_q   <= '0;
                rdata_q <= '0;
                fault_q <= fault_c;
            end else if (state == ACCESS) begin
                cnt_q <= cnt_q + 4'd1;
                if (last_beat && !req_q.store)
                    rdata_q <= load_ext;
            end
        end
    end

    // Bus outputs decode straight from state so reset silences them at once
    always_comb begin
        bus.req_ready        = (state == IDLE);
        bus.resp_valid       = (state == RESP);
        bus.resp_rdata       = rdata_q;
        bus.resp_fault       = fault_q;
        bus.bus_addr         = '0;
        bus.bus_write_enable = '0;
        bus.bus_data_in      = '0;
        if (state == ACCESS) begin
            bus.bus_addr    = req_q.addr;
            bus.bus_data_in = req_q.wdata;
            if (req_q.store) begin
                unique case (req_q.funct3[1:0])
                    2'd2:    bus.bus_write_enable = 3'b001;
                    2'd1:    bus.bus_write_enable = 3'b010;
                    default: bus.bus_write_enable = 3'b100;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized and directed checks of lsu_bus_master against a transaction-level
// model of address, fault, bus-write and load-result rules.
module tb_lsu_bus_master;
    localparam int RL = 3;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    lsu_bus_master_if bif ();

    lsu_bus_master #(.READ_LATENCY(RL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Request fields that must be ignored while the unit is busy
    task automatic drive_junk(input logic v);
        bif.req_valid  = v;
        bif.req_store  = 1'($urandom);
        bif.req_funct3 = 3'($urandom);
        bif.req_base   = $urandom;
        bif.req_offset = $urandom;
        bif.req_wdata  = $urandom;
    endtask

    // Reference: what one request should do, from the ISA-level rules
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] mem, output logic flt, output int acc,
                         output logic [2:0] we, output logic [31:0] rd);
        int   size;
        logic legal;
        byte     sb;
        shortint sh;
        size  = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        flt   = !legal || ((addr % size) != 0);
        acc   = flt ? 0 : (st ? 1 : RL);
        we    = (st && !flt) ? 3'(4 / size) : 3'd0;
        rd    = 32'd0;
        if (!flt && !st) begin
            sb = mem[7:0];
            sh = mem[15:0];
            case (f3)
                3'd0: rd = 32'(int'(sb));
                3'd4: rd = mem & 32'h0000_00FF;
                3'd1: rd = 32'(int'(sh));
                3'd5: rd = mem & 32'h0000_FFFF;
                default: rd = mem;
            endcase
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle again
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd,
                          input logic [31:0] mem, input int hold);
        logic [31:0] addr, rd;
        logic        flt;
        int          acc;
        logic [2:0]  we;
        addr = base + off;
        model(st, f3, addr, mem, flt, acc, we, rd);
        check("req_ready_idle", 32'(bif.req_ready), 32'd1);
        bif.req_valid  = 1'b1;
        bif.req_store  = st;
        bif.req_funct3 = f3;
        bif.req_base   = base;
        bif.req_offset = off;
        bif.req_wdata  = wd;
        bif.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= acc; k++) begin
            drive_junk(1'($urandom));
            bif.bus_data_out = (k == acc) ? mem : $urandom;
            check("access_resp_valid", 32'(bif.resp_valid), 32'd0);
            check("access_req_ready", 32'(bif.req_ready), 32'd0);
            check("access_bus_addr", bif.bus_addr, addr);
            check("access_bus_we", 32'(bif.bus_write_enable), 32'(we));
            check("access_bus_data_in", bif.bus_data_in, wd);
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            drive_junk(h == hold ? 1'b1 : 1'($urandom));
            bif.bus_data_out = $urandom;
            check("resp_valid", 32'(bif.resp_valid), 32'd1);
            check("resp_rdata", bif.resp_rdata, rd);
            check("resp_fault", 32'(bif.resp_fault), 32'(flt));
            check("resp_req_ready", 32'(bif.req_ready), 32'd0);
            check("resp_bus_addr", bif.bus_addr, 32'd0);
            check("resp_bus_we", 32'(bif.bus_write_enable), 32'd0);
            check("resp_bus_data_in", bif.bus_data_in, 32'd0);
            bif.resp_ready = (h == hold);
            @(negedge clk);
        end
        // A request offered in the release cycle must not have been taken
        bif.req_valid  = 1'b0;
        bif.resp_ready = 1'b0;
        check("post_resp_valid", 32'(bif.resp_valid), 32'd0);
        check("post_req_ready", 32'(bif.req_ready), 32'd1);
        check("post_bus_we", 32'(bif.bus_write_enable), 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        st;
        logic [31:0] base, off, r;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bif.resp_ready   = 1'b0;
        bif.bus_data_out = 32'd0;
        drive_junk(1'b1);
        @(negedge clk);
        check("rst_req_ready", 32'(bif.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
        check("rst_resp_rdata", bif.resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(bif.resp_fault), 32'd0);
        check("rst_bus_addr", bif.bus_addr, 32'd0);
        check("rst_bus_we", 32'(bif.bus_write_enable), 32'd0);
        check("rst_bus_data_in", bif.bus_data_in, 32'd0);
        reset = 1'b0;

        // Directed corner cases
        do_txn(1'b1, 3'd2, 32'h1000_0000, 32'd8, 32'hDEAD_BEEF, 32'd0, 0);
        do_txn(1'b0, 3'd0, 32'h1000_0003, 32'd0, 32'd0, 32'h0000_0080, 0);
        do_txn(1'b0, 3'd4, 32'h1000_0003, 32'd0, 32'd0, 32'h0000_0080, 1);
        do_txn(1'b0, 3'd1, 32'h1000_0001, 32'd0, 32'd0, 32'h0000_8001, 0);
        do_txn(1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'd0, 32'h1234_5678, 5);
        do_txn(1'b1, 3'd0, 32'hFFFF_FFFC, 32'd8, 32'h0000_00A5, 32'd0, 0);
        do_txn(1'b0, 3'd1, 32'h0000_0100, 32'd2, 32'd0, 32'h0000_8123, 0);
        do_txn(1'b0, 3'd5, 32'h0000_0100, 32'd2, 32'd0, 32'h0000_8123, 0);
        do_txn(1'b1, 3'd4, 32'h0000_0100, 32'd0, 32'd0, 32'd0, 0);

        // Random traffic, biased toward legal and aligned accesses
        for (int i = 0; i < 80; i++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 3) != 0)
                f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + (($urandom_range(0, 1) != 0) ? 4 : 0));
            else
                f3 = 3'($urandom);
            if (f3 == 3'd6) f3 = 3'd2;
            base = $urandom;
            if ($urandom_range(0, 2) != 0) base = base & 32'hFFFF_FFFC;
            r   = $urandom;
            off = ($urandom_range(0, 1) != 0) ? {{20{r[11]}}, r[11:0]} : (r & 32'hFFFF_FFFC);
            do_txn(st, f3, base, off, $urandom, $urandom, $urandom_range(0, 3));
        end

        // Reset in the middle of a halfword store
        check("sh_req_ready", 32'(bif.req_ready), 32'd1);
        bif.req_valid  = 1'b1;
        bif.req_store  = 1'b1;
        bif.req_funct3 = 3'd1;
        bif.req_base   = 32'h2000_0000;
        bif.req_offset = 32'd2;
        bif.req_wdata  = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        bif.req_valid = 1'b0;
        check("sh_access_we", 32'(bif.bus_write_enable), 32'h2);
        check("sh_access_addr", bif.bus_addr, 32'h2000_0002);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(bif.bus_write_enable), 32'd0);
        check("rst_mid_addr", bif.bus_addr, 32'd0);
        check("rst_mid_resp_valid", 32'(bif.resp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(bif.req_ready), 32'd1);
        @(negedge clk);
        check("rst_hold_resp_valid", 32'(bif.resp_valid), 32'd0);
        reset = 1'b0;
        // Accepted on the first rising edge after release
        do_txn(1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'd0, 32'hCAFE_F00D, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_resp_valid", 32'(bif.resp_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
